fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the CPU core: owns the program counter and fetches 16-bit words

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit_jmp_cond_eval.sv | 21 ++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, jump condition codes and fetch FSM encodings
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int INS_W_DEF  = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;

    localparam logic [2:0] JC_ALWAYS = 3'b000;
    localparam logic [2:0] JC_Z      = 3'b001;
    localparam logic [2:0] JC_NZ     = 3'b010;
    localparam logic [2:0] JC_C      = 3'b011;
    localparam logic [2:0] JC_NC     = 3'b100;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and core-side signals of the fetch stage
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INS_W-1:0]  imem_rdata;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;
    logic              ins_ready;
    logic              jmp_en;
    logic [2:0]        jmp_cond;
    logic              flag_z;
    logic              flag_c;
    logic [ADDR_W-1:0] pc;

    modport master (
        output imem_req, imem_addr, ins, ins_valid, pc,
        input  imem_ack, imem_rdata, ins_ready, jmp_en, jmp_cond, flag_z, flag_c
    );

    modport slave (
        input  imem_req, imem_addr, ins, ins_valid, pc,
        output imem_ack, imem_rdata, ins_ready, jmp_en, jmp_cond, flag_z, flag_c
    );
endinterface

// File: rtl/fetch_unit_jmp_cond_eval.sv
// rtl/fetch_unit_jmp_cond_eval.sv - combinational jump condition decode against ALU flags
module jmp_cond_eval
    import fetch_unit_pkg::*;
(
    input  logic [2:0] jmp_cond,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b0;
        case (jmp_cond)
            JC_ALWAYS: cond_true = 1'b1;
            JC_Z:      cond_true = flag_z;
            JC_NZ:     cond_true = !flag_z;
            JC_C:      cond_true = flag_c;
            JC_NC:     cond_true = !flag_c;
            default:   cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction fetch stage feeding the core
// FETCH_PREFETCH_EN adds a one-entry prefetch buffer with stale-ack discard after taken jumps.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF
)
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    logic [ADDR_W-1:0] fpc;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [INS_W-1:0]  ins_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;

    logic              cond_true;
    logic              xfer;
    logic              taken;
    logic [ADDR_W-1:0] jmp_tgt;

    jmp_cond_eval u_cond (
        .jmp_cond  (bus.jmp_cond),
        .flag_z    (bus.flag_z),
        .flag_c    (bus.flag_c),
        .cond_true (cond_true)
    );

    assign xfer    = valid_q && bus.ins_ready;
    assign taken   = bus.jmp_en && cond_true;
    assign jmp_tgt = ins_q[ADDR_W-1:0];

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.ins       = ins_q;
    assign bus.ins_valid = valid_q;
    assign bus.pc        = pc_q;

`ifdef FETCH_PREFETCH_EN
    logic [INS_W-1:0]  buf_q;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_valid;
    logic              discard_q;
    logic              ack_any;
    logic              ack_live;
    logic [1:0]        occ;
    logic              can_issue;

    assign ack_any  = req_q && bus.imem_ack;
    assign ack_live = ack_any && !discard_q;
    // Words held after this edge; a new request needs a free slot for its data.
    assign occ       = 2'(valid_q) + 2'(buf_valid) + 2'(ack_live) - 2'(xfer);
    assign can_issue = (!req_q || ack_any) && (occ < 2'd2) && !(xfer && taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc       <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            ins_q     <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            buf_q     <= '0;
            buf_addr  <= '0;
            buf_valid <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if (ack_any) begin
                req_q     <= 1'b0;
                discard_q <= 1'b0;
            end
            if (xfer && taken) begin
                valid_q   <= 1'b0;
                buf_valid <= 1'b0;
                fpc       <= jmp_tgt;
                if (req_q && !bus.imem_ack) begin
                    discard_q <= 1'b1;
                end
            end else begin
                if (xfer) begin
                    if (buf_valid) begin
                        ins_q     <= buf_q;
                        pc_q      <= buf_addr;
                        buf_valid <= 1'b0;
                    end else if (ack_live) begin
                        ins_q <= bus.imem_rdata;
                        pc_q  <= addr_q;
                    end else begin
                        valid_q <= 1'b0;
                    end
                    if (buf_valid && ack_live) begin
                        buf_q     <= bus.imem_rdata;
                        buf_addr  <= addr_q;
                        buf_valid <= 1'b1;
                    end
                end else if (ack_live) begin
                    if (!valid_q) begin
                        ins_q   <= bus.imem_rdata;
                        pc_q    <= addr_q;
                        valid_q <= 1'b1;
                    end else begin
                        buf_q     <= bus.imem_rdata;
                        buf_addr  <= addr_q;
                        buf_valid <= 1'b1;
                    end
                end
                if (can_issue) begin
                    req_q  <= 1'b1;
                    addr_q <= fpc;
                    fpc    <= fpc + ADDR_W'(1);
                end
            end
        end
    end
`else
    fetch_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            fpc     <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ins_q   <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // Only the first cycle out of reset arrives here with no request raised.
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= fpc;
                    end else if (bus.imem_ack) begin
                        ins_q   <= bus.imem_rdata;
                        pc_q    <= addr_q;
                        fpc     <= addr_q + ADDR_W'(1);
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= ST_FETCH;
                        if (taken) begin
                            fpc    <= jmp_tgt;
                            addr_q <= jmp_tgt;
                        end else begin
                            addr_q <= fpc;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 12;
    localparam int IW = 16;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic [2:0] cond;
        logic       z;
        logic       c;
    } jmp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .INS_W(IW)) bus ();

    fetch_unit #(.ADDR_W(AW), .INS_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] mem [0:4095];
    exp_t sbq[$];
    jmp_t jq[$];

    int lat       = 1;
    bit mem_auto  = 1'b1;
    bit man_ack   = 1'b0;
    bit cons_en   = 1'b0;
    int ready_pct = 100;
    bit rand_jmp  = 1'b0;
    int n_xfer    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_taken(input jmp_t j);
        bit t;
        case (j.cond)
            3'd0:    t = 1'b1;
            3'd1:    t = j.z;
            3'd2:    t = !j.z;
            3'd3:    t = j.c;
            3'd4:    t = !j.c;
            default: t = 1'b0;
        endcase
        return j.en && t;
    endfunction

    task automatic wait_xfer(input int target, input int budget, input string tag);
        int n = 0;
        while (n_xfer < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 32'(n_xfer >= target), 32'd1);
    endtask

    // Memory responder: acks after lat waiting cycles, drives on the falling edge
    initial begin
        int cnt;
        bit acked;
        logic [AW-1:0] req_addr;
        cnt = 0;
        acked = 1'b0;
        req_addr = '0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (acked || rst) cnt = 0;
            acked = 1'b0;
            bus.imem_ack = 1'b0;
            if (!mem_auto) begin
                bus.imem_ack = man_ack;
                bus.imem_rdata = 16'hDEAD;
                cnt = 0;
            end else if (bus.imem_req && !rst) begin
                if (cnt == 0) req_addr = bus.imem_addr;
                else chk("addr_stable", 32'(bus.imem_addr), 32'(req_addr));
                if (cnt >= lat) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mem[bus.imem_addr];
                    acked = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Core model: accepts words, drives jump stimulus and predicts the next fetch
    initial begin
        bit r;
        bit prev_hold;
        jmp_t j;
        exp_t e;
        logic [AW-1:0] nxt;
        prev_hold = 1'b0;
        bus.ins_ready = 1'b0;
        bus.jmp_en = 1'b0;
        bus.jmp_cond = 3'd0;
        bus.flag_z = 1'b0;
        bus.flag_c = 1'b0;
        forever begin
            @(negedge clk);
            if (!cons_en || rst) begin
                bus.ins_ready = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) chk("valid_held", 32'(bus.ins_valid), 32'd1);
`ifndef FETCH_PREFETCH_EN
            if (bus.ins_valid) chk("no_req_in_hold", 32'(bus.imem_req), 32'd0);
`endif
            if (bus.ins_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("ins", 32'(bus.ins), 32'(sbq[0].ins));
                    chk("pc", 32'(bus.pc), 32'(sbq[0].pc));
                end
            end
            r = ($urandom_range(99) < ready_pct);
            bus.ins_ready = r;
            if (bus.ins_valid && r && sbq.size() > 0) begin
                e = sbq.pop_front();
                if (jq.size() > 0) j = jq.pop_front();
                else if (rand_jmp) j = jmp_t'(5'($urandom));
                else j = '0;
                bus.jmp_en = j.en;
                bus.jmp_cond = j.cond;
                bus.flag_z = j.z;
                bus.flag_c = j.c;
                nxt = model_taken(j) ? e.ins[AW-1:0] : e.pc + AW'(1);
                sbq.push_back(exp_t'{pc: nxt, ins: mem[nxt]});
                n_xfer++;
            end else begin
                j = jmp_t'(5'($urandom));
                bus.jmp_en = j.en;
                bus.jmp_cond = j.cond;
                bus.flag_z = j.z;
                bus.flag_c = j.c;
            end
            prev_hold = bus.ins_valid && !r;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h000] = 16'h1001;
        mem[12'h001] = 16'h2002;
        mem[12'h002] = 16'h3003;
        mem[12'h003] = 16'h8123;
        mem[12'h123] = 16'h8005;
        mem[12'h124] = 16'h8200;
        mem[12'h125] = 16'h8300;
        mem[12'h300] = 16'h8400;
        mem[12'h400] = 16'h8500;
        mem[12'h401] = 16'h8FFF;
        mem[12'hFFF] = 16'h8040;

        jq.push_back('{1'b0, 3'd0, 1'b0, 1'b0});
        jq.push_back('{1'b0, 3'd0, 1'b0, 1'b0});
        jq.push_back('{1'b0, 3'd0, 1'b0, 1'b0});
        jq.push_back('{1'b1, 3'd1, 1'b1, 1'b0});
        jq.push_back('{1'b1, 3'd1, 1'b0, 1'b0});
        jq.push_back('{1'b1, 3'd5, 1'b1, 1'b1});
        jq.push_back('{1'b1, 3'd2, 1'b0, 1'b0});
        jq.push_back('{1'b1, 3'd3, 1'b0, 1'b1});
        jq.push_back('{1'b1, 3'd4, 1'b0, 1'b1});
        jq.push_back('{1'b1, 3'd0, 1'b0, 1'b0});
        jq.push_back('{1'b0, 3'd0, 1'b1, 1'b1});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.ins_valid), 32'd0);
        chk("rst_ins", 32'(bus.ins), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);

        sbq.push_back(exp_t'{pc: 12'h000, ins: mem[12'h000]});
        lat = 1;
        ready_pct = 100;
        cons_en = 1'b1;
        rst = 1'b0;

        wait_xfer(2, 40, "seq_start");
        ready_pct = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_valid", 32'(bus.ins_valid), 32'd1);
        ready_pct = 100;
        wait_xfer(16, 200, "directed_chain");

        ready_pct = 60;
        wait_xfer(30, 300, "seq_stall_mix");

        mem_auto = 1'b0;
        man_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.imem_req && n < 50);
        chk("t6_req_seen", 32'(bus.imem_req), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cons_en = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
        chk("t6_rst_valid", 32'(bus.ins_valid), 32'd0);
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_late_ack_valid", 32'(bus.ins_valid), 32'd0);
        man_ack = 1'b0;
        sbq.delete();
        jq.delete();
        sbq.push_back(exp_t'{pc: 12'h000, ins: mem[12'h000]});
        rand_jmp = 1'b0;
        ready_pct = 100;
        lat = 0;
        mem_auto = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.imem_req && n < 20);
        chk("t6_first_addr", 32'(bus.imem_addr), 32'd0);
        cons_en = 1'b1;
        @(negedge clk);
        chk("t6_min_latency", 32'(bus.ins_valid), 32'd1);
        n = n_xfer;
        wait_xfer(n + 4, 60, "t6_restart");

        rand_jmp = 1'b1;
        ready_pct = 70;
        n = n_xfer;
        for (int k = 0; k < 40; k++) begin
            lat = $urandom_range(0, 2);
            repeat (12) @(posedge clk);
        end
        wait_xfer(n + 60, 400, "random_phase");

        cons_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
